// File: rtl/ws2812_buffer_ctrl.sv
// Double-buffered pixel store between a host writer and a WS2812 strip driver.
// Optional WS2812_BUFFER_COPY_EN: after a swap, copy the new front bank into the back bank.
module ws2812_buffer_ctrl #(
    parameter int LED_COUNT = 240
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [8:0]  host_addr_i,
    input  logic [23:0] host_rgb_i,
    input  logic        host_we_i,
    output logic        host_ready_o,
    input  logic        host_swap_i,
    output logic        swap_pending_o,
    output logic        swap_done_o,
    output logic        front_bank_o,
    input  logic [8:0]  drv_address_i,
    output logic [7:0]  drv_r_o,
    output logic [7:0]  drv_g_o,
    output logic [7:0]  drv_b_o,
    input  logic        frame_sync_i,
    output logic        wr_drop_o
);

    localparam int         AW    = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
    localparam logic [9:0] COUNT = 10'(LED_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        PENDING
`ifdef WS2812_BUFFER_COPY_EN
        , COPY
`endif
    } state_t;

    state_t state;

    logic [23:0] mem [0:1][0:LED_COUNT-1];

    logic          host_in_range;
    logic          drv_in_range;
    logic          accept;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;

`ifdef WS2812_BUFFER_COPY_EN
    localparam logic [8:0] LAST = 9'(LED_COUNT - 1);
    logic [8:0] copy_cnt;
`endif

    assign host_in_range = {1'b0, host_addr_i} < COUNT;
    assign drv_in_range  = {1'b0, drv_address_i} < COUNT;
    assign accept        = host_we_i && host_ready_o;

    // Single back-bank write port shared by host writes and the copy engine;
    // the two never overlap because host_ready_o is low during COPY.
    always_comb begin
        wr_en   = accept && host_in_range && !rst_i;
        wr_addr = host_addr_i[AW-1:0];
        wr_data = host_rgb_i;
`ifdef WS2812_BUFFER_COPY_EN
        if (state == COPY) begin
            wr_en   = !rst_i;
            wr_addr = copy_cnt[AW-1:0];
            wr_data = mem[front_bank_o][copy_cnt[AW-1:0]];
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[~front_bank_o][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            {drv_r_o, drv_g_o, drv_b_o} <= '0;
        end else if (drv_in_range) begin
            {drv_r_o, drv_g_o, drv_b_o} <= mem[front_bank_o][drv_address_i[AW-1:0]];
        end else begin
            {drv_r_o, drv_g_o, drv_b_o} <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            front_bank_o   <= 1'b0;
            swap_pending_o <= 1'b0;
            swap_done_o    <= 1'b0;
            wr_drop_o      <= 1'b0;
            host_ready_o   <= 1'b1;
`ifdef WS2812_BUFFER_COPY_EN
            copy_cnt       <= '0;
`endif
        end else begin
            swap_done_o <= 1'b0;
            wr_drop_o   <= accept && !host_in_range;
            case (state)
                IDLE: begin
                    if (host_swap_i && frame_sync_i) begin
                        front_bank_o <= ~front_bank_o;
                        swap_done_o  <= 1'b1;
`ifdef WS2812_BUFFER_COPY_EN
                        state        <= COPY;
                        host_ready_o <= 1'b0;
                        copy_cnt     <= '0;
`endif
                    end else if (host_swap_i) begin
                        state          <= PENDING;
                        swap_pending_o <= 1'b1;
                        host_ready_o   <= 1'b0;
                    end
                end
                PENDING: begin
                    if (frame_sync_i) begin
                        front_bank_o   <= ~front_bank_o;
                        swap_done_o    <= 1'b1;
                        swap_pending_o <= 1'b0;
`ifdef WS2812_BUFFER_COPY_EN
                        state          <= COPY;
                        copy_cnt       <= '0;
`else
                        state          <= IDLE;
                        host_ready_o   <= 1'b1;
`endif
                    end
                end
`ifdef WS2812_BUFFER_COPY_EN
                COPY: begin
                    if (copy_cnt == LAST) begin
                        state        <= IDLE;
                        host_ready_o <= 1'b1;
                        copy_cnt     <= '0;
                    end else begin
                        copy_cnt <= copy_cnt + 9'd1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_buffer_ctrl.sv
// Randomised bench for ws2812_buffer_ctrl against a transaction-level bank model.
// Honours WS2812_BUFFER_COPY_EN in the model when the build defines it.
module tb_ws2812_buffer_ctrl;

    localparam int N = 240;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [8:0]  host_addr_i = '0;
    logic [23:0] host_rgb_i = '0;
    logic        host_we_i = 1'b0;
    logic        host_ready_o;
    logic        host_swap_i = 1'b0;
    logic        swap_pending_o;
    logic        swap_done_o;
    logic        front_bank_o;
    logic [8:0]  drv_address_i = '0;
    logic [7:0]  drv_r_o, drv_g_o, drv_b_o;
    logic        frame_sync_i = 1'b0;
    logic        wr_drop_o;

    ws2812_buffer_ctrl #(.LED_COUNT(N)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .host_addr_i    (host_addr_i),
        .host_rgb_i     (host_rgb_i),
        .host_we_i      (host_we_i),
        .host_ready_o   (host_ready_o),
        .host_swap_i    (host_swap_i),
        .swap_pending_o (swap_pending_o),
        .swap_done_o    (swap_done_o),
        .front_bank_o   (front_bank_o),
        .drv_address_i  (drv_address_i),
        .drv_r_o        (drv_r_o),
        .drv_g_o        (drv_g_o),
        .drv_b_o        (drv_b_o),
        .frame_sync_i   (frame_sync_i),
        .wr_drop_o      (wr_drop_o)
    );

    always #5 clk = ~clk;

`ifdef WS2812_BUFFER_COPY_EN
    localparam int COPY_LEN = N;
`else
    localparam int COPY_LEN = 0;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Model: two banks addressed by absolute bank number, plus "contents known" flags
    // since pixel RAM is not initialised by reset.
    logic [23:0] bank  [2][N];
    bit          known [2][N];
    bit          m_front = 0;
    bit          m_pending = 0;
    int          m_copy_left = 0;
    bit          started = 0;

    logic        exp_ready, exp_pending, exp_done, exp_drop, exp_front;
    logic [23:0] exp_rgb;
    bit          exp_rgb_chk;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit ready;
        bit do_swap;
        int idx;
        started = 1;
        if (rst_i) begin
            m_front = 0; m_pending = 0; m_copy_left = 0;
            exp_done = 0; exp_drop = 0; exp_rgb = '0; exp_rgb_chk = 1;
        end else begin
            ready = !m_pending && (m_copy_left == 0);
            if (drv_address_i < N) begin
                exp_rgb     = bank[m_front][drv_address_i];
                exp_rgb_chk = known[m_front][drv_address_i];
            end else begin
                exp_rgb = '0; exp_rgb_chk = 1;
            end
            exp_drop = host_we_i && ready && (host_addr_i >= N);
            if (host_we_i && ready && host_addr_i < N) begin
                bank[!m_front][host_addr_i]  = host_rgb_i;
                known[!m_front][host_addr_i] = 1;
            end
            if (m_copy_left > 0) begin
                idx = N - m_copy_left;
                bank[!m_front][idx]  = bank[m_front][idx];
                known[!m_front][idx] = known[m_front][idx];
                m_copy_left--;
            end
            do_swap  = frame_sync_i && (m_pending || (ready && host_swap_i));
            exp_done = do_swap;
            if (do_swap) begin
                m_front     = !m_front;
                m_pending   = 0;
                m_copy_left = COPY_LEN;
            end else if (ready && host_swap_i) begin
                m_pending = 1;
            end
        end
        exp_front   = m_front;
        exp_pending = m_pending;
        exp_ready   = !m_pending && (m_copy_left == 0);
    end

    always @(negedge clk) begin
        if (started) begin
            chk("front_bank", {23'd0, front_bank_o}, {23'd0, exp_front});
            chk("swap_pending", {23'd0, swap_pending_o}, {23'd0, exp_pending});
            chk("swap_done", {23'd0, swap_done_o}, {23'd0, exp_done});
            chk("wr_drop", {23'd0, wr_drop_o}, {23'd0, exp_drop});
            chk("host_ready", {23'd0, host_ready_o}, {23'd0, exp_ready});
            if (exp_rgb_chk) chk("drv_rgb", {drv_r_o, drv_g_o, drv_b_o}, exp_rgb);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!host_ready_o && n < 2000) begin
            step();
            n++;
        end
        chk("ready_timeout", {23'd0, host_ready_o}, 24'd1);
    endtask

    task automatic fill_back();
        for (int i = 0; i < N; i++) begin
            host_we_i = 1; host_addr_i = 9'(i); host_rgb_i = 24'($urandom);
            step();
        end
        host_we_i = 0;
    endtask

    initial begin
        step(); step();
        chk("reset_ready", {23'd0, host_ready_o}, 24'd1);
        chk("reset_front", {23'd0, front_bank_o}, 24'd0);
        chk("reset_rgb", {drv_r_o, drv_g_o, drv_b_o}, 24'd0);
        rst_i = 0;

        fill_back();
        host_we_i = 1; host_addr_i = 9'd5; host_rgb_i = 24'h112233;
        step();
        host_we_i = 0; host_swap_i = 1;
        step();
        host_swap_i = 0;
        chk("pending_set", {23'd0, swap_pending_o}, 24'd1);
        host_we_i = 1; host_addr_i = 9'd0; host_rgb_i = 24'hABCDEF;
        step();
        host_we_i = 0;
        chk("pending_ready_low", {23'd0, host_ready_o}, 24'd0);
        chk("pending_held", {23'd0, swap_pending_o}, 24'd1);
        frame_sync_i = 1;
        step();
        frame_sync_i = 0;
        chk("done_pulse", {23'd0, swap_done_o}, 24'd1);
        chk("front_one", {23'd0, front_bank_o}, 24'd1);
        chk("ready_after_swap", {23'd0, host_ready_o}, (COPY_LEN == 0) ? 24'd1 : 24'd0);
        drv_address_i = 9'd5;
        step();
        chk("drv_r5", {16'd0, drv_r_o}, 24'h11);
        chk("drv_g5", {16'd0, drv_g_o}, 24'h22);
        chk("drv_b5", {16'd0, drv_b_o}, 24'h33);
        wait_ready();

        fill_back();
        host_swap_i = 1; frame_sync_i = 1;
        step();
        host_swap_i = 0; frame_sync_i = 0;
        chk("direct_front", {23'd0, front_bank_o}, 24'd0);
        chk("direct_no_pending", {23'd0, swap_pending_o}, 24'd0);
        wait_ready();

        host_we_i = 1; host_addr_i = 9'(N); host_rgb_i = 24'hDEAD00;
        step();
        host_we_i = 0;
        chk("drop_pulse", {23'd0, wr_drop_o}, 24'd1);
        step();
        chk("drop_once", {23'd0, wr_drop_o}, 24'd0);

`ifdef WS2812_BUFFER_COPY_EN
        host_swap_i = 1; frame_sync_i = 1;
        step();
        host_swap_i = 0; frame_sync_i = 0;
        for (int i = 0; i < 20; i++) step();
        rst_i = 1;
        step();
        rst_i = 0;
        chk("copy_rst_front", {23'd0, front_bank_o}, 24'd0);
        chk("copy_rst_ready", {23'd0, host_ready_o}, 24'd1);
`endif

        for (int c = 0; c < 4000; c++) begin
            host_we_i     = ($urandom_range(1, 0) == 1);
            host_addr_i   = 9'($urandom_range(N + 15, 0));
            host_rgb_i    = 24'($urandom);
            host_swap_i   = ($urandom_range(19, 0) == 0);
            frame_sync_i  = ($urandom_range(24, 0) == 0);
            drv_address_i = 9'($urandom_range(N + 3, 0));
            rst_i         = ($urandom_range(499, 0) == 0);
            step();
        end
        rst_i = 0; host_we_i = 0; host_swap_i = 0; frame_sync_i = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
